// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: opcode/func3 codes, FSM states and special-result helper
// for the iterative RV32M multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic [6:0] EXE_OP_OP        = 7'b0110011;
  localparam logic [6:0] EXE_FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] EXE_FUNC3_MUL    = 3'b000;
  localparam logic [2:0] EXE_FUNC3_MULH   = 3'b001;
  localparam logic [2:0] EXE_FUNC3_MULHSU = 3'b010;
  localparam logic [2:0] EXE_FUNC3_MULHU  = 3'b011;
  localparam logic [2:0] EXE_FUNC3_DIV    = 3'b100;
  localparam logic [2:0] EXE_FUNC3_DIVU   = 3'b101;
  localparam logic [2:0] EXE_FUNC3_REM    = 3'b110;
  localparam logic [2:0] EXE_FUNC3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // RISC-V mandated results for divide-by-zero and signed overflow
  function automatic logic [31:0] md_special(
    input logic [2:0]  f3,
    input logic        dz,
    input logic [31:0] dvd
  );
    if (dz) return f3[1] ? dvd : 32'hFFFF_FFFF;
    return f3[1] ? 32'h0 : 32'h8000_0000;
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step: one shift-add multiply or restoring divide iteration.
// mode=1 divides; q_bit is the quotient bit or the product bit shifted out.
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            mode,
  input  logic [XLEN-1:0] part,
  input  logic [XLEN-1:0] opnd,
  input  logic            bit_in,
  output logic [XLEN-1:0] part_next,
  output logic            q_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, part} + (bit_in ? {1'b0, opnd} : '0);
    shl  = {part, bit_in};
    diff = shl - {1'b0, opnd};
    if (mode) begin
      q_bit     = ~diff[XLEN];
      part_next = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
    end else begin
      q_bit     = sum[0];
      part_next = sum[XLEN:1];
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide in EX; stalls upstream while busy.
// Define MULDIV_EARLY_OUT_EN to let zero/overflow cases skip the iteration.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_func3,
  input  logic [6:0]      in_func7,
  input  logic [XLEN-1:0] in_reg1,
  input  logic [XLEN-1:0] in_reg2,
  input  logic [4:0]      in_wd,
  input  logic            in_wreg,
  output logic            stall_req,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_wd,
  output logic            out_wreg
);

  import ex_muldiv_pkg::*;

  md_state_e state, state_nx;

  logic [4:0]      cnt;
  logic [2:0]      f3;
  logic            neg1, neg2, dz, ov;
  logic [XLEN-1:0] hi, lo, opnd;
  logic [4:0]      wd;
  logic            wreg;

  logic            start, is_div, s1, s2, n1, n2;
  logic            dz_in, ov_in, early;
  logic [XLEN-1:0] m1, m2;
`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] early_res;
`endif

  always_comb begin
    start = (state == MD_IDLE) && !flush &&
            (in_opcode == EXE_OP_OP) &&
            (in_func7 == EXE_FUNC7_MULDIV);
    is_div = in_func3[2];
    s1 = 1'b0;
    s2 = 1'b0;
    unique case (in_func3)
      EXE_FUNC3_MULH,
      EXE_FUNC3_DIV,
      EXE_FUNC3_REM: begin
        s1 = 1'b1;
        s2 = 1'b1;
      end
      EXE_FUNC3_MULHSU: s1 = 1'b1;
      default: ;
    endcase
    n1 = s1 & in_reg1[XLEN-1];
    n2 = s2 & in_reg2[XLEN-1];
    m1 = n1 ? -in_reg1 : in_reg1;
    m2 = n2 ? -in_reg2 : in_reg2;
    dz_in = is_div && (in_reg2 == '0);
    ov_in = is_div && !in_func3[0] &&
            (in_reg1 == {1'b1, {(XLEN-1){1'b0}}}) &&
            (in_reg2 == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early = dz_in || ov_in ||
            (!is_div && (in_reg1 == '0 || in_reg2 == '0));
    early_res = is_div ? md_special(in_func3, dz_in, in_reg1) : '0;
`else
    early = 1'b0;
`endif
  end

  logic            mode, bit_in, q_bit;
  logic [XLEN-1:0] part_nx, lo_nx;

  // lo holds the multiplier (shifted right) or dividend/quotient (shifted left)
  assign mode   = f3[2];
  assign bit_in = mode ? lo[XLEN-1] : lo[0];
  assign lo_nx  = mode ? {lo[XLEN-2:0], q_bit} : {q_bit, lo[XLEN-1:1]};

  ex_muldiv_step #(.XLEN(XLEN)) u_step (
    .mode      (mode),
    .part      (hi),
    .opnd      (opnd),
    .bit_in    (bit_in),
    .part_next (part_nx),
    .q_bit     (q_bit)
  );

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res;

  always_comb begin
    prod = {part_nx, lo_nx};
    if (neg1 ^ neg2) prod = -prod;
    quo = (neg1 ^ neg2) ? -lo_nx : lo_nx;
    rem = neg1 ? -part_nx : part_nx;
    unique case (f3)
      EXE_FUNC3_MUL: res = prod[XLEN-1:0];
      EXE_FUNC3_MULH,
      EXE_FUNC3_MULHSU,
      EXE_FUNC3_MULHU: res = prod[2*XLEN-1:XLEN];
      EXE_FUNC3_DIV,
      EXE_FUNC3_DIVU: res = quo;
      default: res = rem;
    endcase
    if (dz || ov) res = md_special(f3, dz, rem);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      MD_IDLE: if (start) state_nx = early ? MD_DONE : MD_CALC;
      MD_CALC: if (cnt == 5'd31) state_nx = MD_DONE;
      MD_DONE: state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
    if (flush) state_nx = MD_IDLE;
  end

  always_comb begin
    stall_req = start || (state == MD_CALC);
    busy      = (state != MD_IDLE);
    out_valid = (state == MD_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      f3       <= '0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      dz       <= 1'b0;
      ov       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      wd       <= '0;
      wreg     <= 1'b0;
      out_data <= '0;
      out_wd   <= '0;
      out_wreg <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      f3   <= in_func3;
      neg1 <= n1;
      neg2 <= n2;
      dz   <= dz_in;
      ov   <= ov_in;
      hi   <= '0;
      lo   <= is_div ? m1 : m2;
      opnd <= is_div ? m2 : m1;
      wd   <= in_wd;
      wreg <= in_wreg;
`ifdef MULDIV_EARLY_OUT_EN
      if (early) begin
        out_data <= early_res;
        out_wd   <= in_wd;
        out_wreg <= in_wreg;
      end
`endif
    end else if (state == MD_CALC && !flush) begin
      hi  <= part_nx;
      lo  <= lo_nx;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        out_data <= res;
        out_wd   <= wd;
        out_wreg <= wreg;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed scoreboard bench for ex_muldiv.
// Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_ex_muldiv;

  localparam logic [6:0] OP_OP = 7'b0110011;
  localparam logic [6:0] F7_MD = 7'b0000001;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [6:0]  in_opcode, in_func7;
  logic [2:0]  in_func3;
  logic [31:0] in_reg1, in_reg2;
  logic [4:0]  in_wd;
  logic        in_wreg;
  logic        stall_req, busy, out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_wd;
  logic        out_wreg;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_opcode (in_opcode),
    .in_func3  (in_func3),
    .in_func7  (in_func7),
    .in_reg1   (in_reg1),
    .in_reg2   (in_reg2),
    .in_wd     (in_wd),
    .in_wreg   (in_wreg),
    .stall_req (stall_req),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_wd    (out_wd),
    .out_wreg  (out_wreg)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  wd;
    logic        wreg;
  } exp_t;

  exp_t  scb[$];
  int    total = 0;
  int    bad = 0;
  string cur = "init";

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, exp);
    end
  endtask

  task automatic bubble();
    in_opcode = OP_OP;
    in_func7  = 7'b0000000;
    in_func3  = 3'b000;
    in_reg1   = 32'h11;
    in_reg2   = 32'h22;
    in_wd     = 5'd3;
    in_wreg   = 1'b1;
  endtask

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd,
                         input logic wreg);
    in_opcode = OP_OP;
    in_func7  = F7_MD;
    in_func3  = f3;
    in_reg1   = a;
    in_reg2   = b;
    in_wd     = wd;
    in_wreg   = wreg;
  endtask

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2])
      return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sbv, ua, ub, p;
    int ia, ib;
    bit ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    ref_md = '0;
    case (f3)
      3'd0: begin p = ua * ub; ref_md = p[31:0]; end
      3'd1: begin p = sa * sbv; ref_md = p[63:32]; end
      3'd2: begin p = sa * ub; ref_md = p[63:32]; end
      3'd3: begin p = ua * ub; ref_md = p[63:32]; end
      3'd4: ref_md = (b == 0) ? 32'hFFFF_FFFF :
                     ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: ref_md = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_md = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: ref_md = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wreg,
                        input logic [31:0] exp);
    int   k, stall_bad, lat;
    bit   got;
    exp_t e;
    cur = name;
    lat = (EARLY && is_fast(f3, a, b)) ? 1 : 33;
    scb.push_back('{data: exp, wd: wd, wreg: wreg});
    @(posedge clk);
    #1;
    drive_m(f3, a, b, wd, wreg);
    k = 0;
    got = 1'b0;
    stall_bad = 0;
    while (!got && k <= 40) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        if (!stall_req || (k > 0 && !busy)) stall_bad++;
        k++;
      end
    end
    chk("no_timeout", 64'(got), 64'd1);
    chk("latency", 64'(k), 64'(lat));
    chk("stall_while_busy", 64'(stall_bad), 64'd0);
    chk("stall_in_done", 64'(stall_req), 64'd0);
    e = scb.pop_front();
    chk("data", 64'(out_data), 64'(e.data));
    chk("wd", 64'(out_wd), 64'(e.wd));
    chk("wreg", 64'(out_wreg), 64'(e.wreg));
    bubble();
    @(negedge clk);
    chk("valid_one_cycle", 64'(out_valid), 64'd0);
    chk("data_hold", 64'(out_data), 64'(e.data));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;

    rst = 1'b1;
    flush = 1'b0;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    cur = "reset";
    chk("stall_req", 64'(stall_req), 64'd0);
    chk("busy", 64'(busy), 64'd0);
    chk("out_valid", 64'(out_valid), 64'd0);
    chk("out_data", 64'(out_data), 64'd0);
    chk("out_wd", 64'(out_wd), 64'd0);
    chk("out_wreg", 64'(out_wreg), 64'd0);

    cur = "add_ignored";
    repeat (5) begin
      @(negedge clk);
      chk("stall_busy_valid", 64'({stall_req, busy, out_valid}), 64'd0);
    end

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b1, 32'hFFFF_FFEB);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'hFFFF_FFFE);
    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b0, 32'hFFFF_FFFF);
    run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 32'hFFFF_FFFD);
    run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd7, 32'd2, 5'd7, 1'b1, 32'd3);
    run_op("remu", 3'd7, 32'd7, 32'd2, 5'd8, 1'b1, 32'd1);
    run_op("div_by0", 3'd4, 32'd5, 32'd0, 5'd9, 1'b1, 32'hFFFF_FFFF);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd10, 1'b1, 32'd5);
    run_op("div_neg_by0", 3'd4, 32'hFFFF_FFEC, 32'd0, 5'd11, 1'b1, 32'hFFFF_FFFF);
    run_op("rem_neg_by0", 3'd6, 32'hFFFF_FFEC, 32'd0, 5'd12, 1'b1, 32'hFFFF_FFEC);
    run_op("remu_by0", 3'd7, 32'd9, 32'd0, 5'd13, 1'b1, 32'd9);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h0);
    run_op("divu_big", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'h0);
    run_op("mul_zero", 3'd0, 32'h0, 32'h1234_5678, 5'd17, 1'b1, 32'h0);

    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'd1);
      run_op("rand", f, a, b, 5'(i + 20), 1'b1, ref_md(f, a, b));
    end

    cur = "flush";
    @(posedge clk);
    #1;
    drive_m(3'd4, 32'd100, 32'd7, 5'd30, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    bubble();
    @(negedge clk);
    chk("valid_in_flush", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("stall_after", 64'(stall_req), 64'd0);
    chk("valid_after", 64'(out_valid), 64'd0);
    run_op("mul_after_flush", 3'd0, 32'd6, 32'd7, 5'd31, 1'b1, 32'd42);

    cur = "rst_mid";
    @(posedge clk);
    #1;
    drive_m(3'd0, 32'd3, 32'd5, 5'd20, 1'b1);
    repeat (6) @(negedge clk);
    chk("busy_in_calc", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bubble();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("stall_req", 64'(stall_req), 64'd0);
    chk("busy", 64'(busy), 64'd0);
    chk("out_valid", 64'(out_valid), 64'd0);
    chk("out_data", 64'(out_data), 64'd0);
    chk("out_wd", 64'(out_wd), 64'd0);
    chk("out_wreg", 64'(out_wreg), 64'd0);

    run_op("after_rst", 3'd5, 32'd1000, 32'd7, 5'd21, 1'b1, 32'd142);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit at the receiving end of the ID/EX pipeline register. Accepts the decoded instruction fields and operands latched into EX, recognises M-extension instructions, and computes the result over multiple cycles. While busy it raises `stall_req` to freeze IF/ID/ID-EX. It then presents one registered result beat toward EX/MEM.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  pipeline flush; abandons any operation in progress.
- `in_opcode`  in  7  opcode from ID/EX.
- `in_func3`  in  3  func3 from ID/EX; selects the M op.
- `in_func7`  in  7  func7 from ID/EX.
- `in_reg1`  in  XLEN  rs1 operand (dividend/multiplicand).
- `in_reg2`  in  XLEN  rs2 operand (divisor/multiplier).
- `in_wd`  in  5  destination register address.
- `in_wreg`  in  1  write-enable of the instruction.
- `stall_req`  out  1  request to hold upstream stages.
- `busy`  out  1  unit is not in IDLE.
- `out_valid`  out  1  one-cycle result strobe.
- `out_data`  out  XLEN  result.
- `out_wd`  out  5  destination address captured at start.
- `out_wreg`  out  1  write-enable captured at start.

## Operation
- Start condition: state IDLE, `flush`=0, `in_opcode`=0110011, `in_func7`=0000001.
- At start, capture func3, wd, wreg, operand magnitudes, and sign flags:
  - MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed only.
  - Others: unsigned.
- States:
  - IDLE → CALC on start.
  - CALC → DONE when the step counter reaches 31.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on `flush`.
- Multiply: shift-add, one multiplier bit per cycle, into a 64-bit product.
  - MUL returns the low 32 bits.
  - MULH/MULHSU/MULHU return the high 32 bits.
  - The product is negated first when the operand signs differ.
- Divide: restoring, one quotient bit per cycle; 5-bit counter, 33-bit partial remainder.
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
- Special results (RISC-V mandated), forced in DONE:
  - Divide by 0: quotient = FFFFFFFF, remainder = dividend.
  - Signed overflow (80000000 / FFFFFFFF): quotient = 80000000, remainder = 0.
- Non-M instructions are ignored; all outputs stay idle.

## Timing
- Reset: state IDLE, counter 0; `stall_req`, `busy`, `out_valid`, `out_data`, `out_wd`, `out_wreg` all 0.
- `stall_req` = (start condition, combinational) OR state==CALC.
  - It is high in the start cycle T, so ID/EX holds.
  - It is low in DONE, so the pipeline advances with the result.
- Latency:
  - Start sampled at edge ending cycle T.
  - CALC occupies cycles T+1..T+32.
  - DONE is cycle T+33: `out_valid`=1 for exactly one cycle, with `out_data`/`out_wd`/`out_wreg` valid.
- Back-to-back: in DONE, ID/EX still holds the old instruction, and start is not evaluated in DONE. The next M instruction can start at T+34 at the earliest.
- `out_data`/`out_wd`/`out_wreg` hold their last value after DONE; only `out_valid` qualifies them.
- Flush:
  - Next state is IDLE and `out_valid`=0.
  - A start coincident with flush is ignored.
  - A flush in DONE does not suppress that cycle's `out_valid`; the MEM side drops it.
- `rst` mid-operation behaves as flush and also clears the outputs.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - Divide by zero, signed overflow, and multiply with either operand zero skip CALC.
  - IDLE → DONE directly, so `out_valid` is at T+1.
  - `stall_req` is high only in cycle T.
- Undefined: every operation takes the full 33-cycle path. Special results are still forced in DONE.

## Structure
- Add to `defines.v`:
  - `EXE_OP_OP` (0110011) and `EXE_FUNC7_MULDIV` (0000001).
  - func3 codes `EXE_FUNC3_MUL..EXE_FUNC3_REMU`.
  - State encodings `MD_IDLE`, `MD_CALC`, `MD_DONE`.
- One sub-module: `ex_muldiv_step`, a combinational single iteration. Inputs: mode, partial remainder/product, operand bit. Outputs: next partial value and quotient bit.
- FSM, counter, sign handling and special-case muxing stay in `ex_muldiv`.

## Test plan
- MUL 7 × FFFFFFFD (−3) → `out_data`=FFFFFFEB at T+33; `stall_req` high T..T+32.
- MULHU FFFFFFFF × FFFFFFFF → FFFFFFFE; MULH same operands → 00000000; MULHSU FFFFFFFF × 2 → FFFFFFFF.
- DIV FFFFFFF9 (−7) / 2 → FFFFFFFD; REM same → FFFFFFFF; DIVU 7/2 → 3; REMU → 1.
- DIV 5/0 → FFFFFFFF, REM 5/0 → 5; DIV 80000000/FFFFFFFF → 80000000, REM → 0. With `MULDIV_EARLY_OUT_EN`, each result is at T+1.
- Flush at T+10 of a DIV → IDLE at T+11, no `out_valid`, `stall_req` low; a new MUL started at T+12 completes normally.
- ADD (func7=0000000) presented for 5 cycles → `stall_req`, `busy`, `out_valid` stay 0; `rst` during CALC clears all outputs next cycle.
